// File: rtl/tone_detector.sv
// Square-wave period meter with a 4-entry note matcher and lock tracking.
// A note locks after LOCK_COUNT consecutive matching periods; silence unlocks it.
module tone_detector #(
    parameter int PER_W      = 24,
    parameter int NOTE0_PER  = 370370,
    parameter int NOTE1_PER  = 277008,
    parameter int NOTE2_PER  = 261096,
    parameter int NOTE3_PER  = 196078,
    parameter int TOL_SHIFT  = 4,
    parameter int LOCK_COUNT = 3,
    parameter int MAX_PERIOD = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             audio_in,
    output logic             note_valid,
    output logic [1:0]       note_code,
    output logic             note_start,
    output logic             note_end,
    output logic [PER_W-1:0] period_out,
    output logic             period_stb
);

    typedef enum logic [1:0] {IDLE, ARMED, TRACK, LOCKED} state_e;

    localparam int HW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [HW-1:0]    LOCK_C = HW'(LOCK_COUNT);
    localparam logic [HW-1:0]    ONE_C  = HW'(1);
    localparam logic [PER_W-1:0] MAX_C  = PER_W'(MAX_PERIOD);
    localparam logic [PER_W:0]   N0_C   = (PER_W+1)'(NOTE0_PER);
    localparam logic [PER_W:0]   N1_C   = (PER_W+1)'(NOTE1_PER);
    localparam logic [PER_W:0]   N2_C   = (PER_W+1)'(NOTE2_PER);
    localparam logic [PER_W:0]   N3_C   = (PER_W+1)'(NOTE3_PER);

    state_e           state_q;
    logic             sync1_q, sync2_q, dly_q;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [1:0]       cand_q;
    logic [HW-1:0]    hits_q;
    logic [HW-1:0]    hits_inc;
    logic             rise;
    logic [PER_W:0]   per_p;
    logic [3:0]       m;
    logic             hit;
    logic [1:0]       idx;

    // Compare in PER_W+1 bits so P = MAX+1 never wraps into a false match.
    function automatic logic in_tol(input logic [PER_W:0] p,
                                    input logic [PER_W:0] n);
        logic [PER_W:0] d;
        d = (p >= n) ? (p - n) : (n - p);
        return d <= (n >> TOL_SHIFT);
    endfunction

    always_comb begin
        rise      = sync2_q & ~dly_q;
        per_p     = {1'b0, per_cnt_q} + (PER_W+1)'(1);
        hits_inc  = hits_q + ONE_C;
        per_cnt_d = per_cnt_q;
        if (rise)
            per_cnt_d = '0;
        else if (per_cnt_q != MAX_C)
            per_cnt_d = per_cnt_q + PER_W'(1);
        m[0] = in_tol(per_p, N0_C);
        m[1] = in_tol(per_p, N1_C);
        m[2] = in_tol(per_p, N2_C);
        m[3] = in_tol(per_p, N3_C);
        hit  = |m;
        idx  = 2'd0;
        priority case (1'b1)
            m[0]:    idx = 2'd0;
            m[1]:    idx = 2'd1;
            m[2]:    idx = 2'd2;
            m[3]:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            dly_q      <= 1'b0;
            per_cnt_q  <= '0;
            cand_q     <= 2'd0;
            hits_q     <= '0;
            note_valid <= 1'b0;
            note_code  <= 2'd0;
            note_start <= 1'b0;
            note_end   <= 1'b0;
            period_out <= '0;
            period_stb <= 1'b0;
        end else begin
            sync1_q    <= audio_in;
            sync2_q    <= sync1_q;
            dly_q      <= sync2_q;
            per_cnt_q  <= per_cnt_d;
            note_start <= 1'b0;
            note_end   <= 1'b0;
            period_stb <= 1'b0;
            if (rise) begin
                if (state_q != IDLE) begin
                    period_out <= per_p[PER_W-1:0];
                    period_stb <= 1'b1;
                end
                unique case (state_q)
                    IDLE: state_q <= ARMED;
                    ARMED: begin
                        if (hit) begin
                            cand_q <= idx;
                            hits_q <= ONE_C;
                            if (LOCK_COUNT == 1) begin
                                state_q    <= LOCKED;
                                note_valid <= 1'b1;
                                note_code  <= idx;
                                note_start <= 1'b1;
                            end else begin
                                state_q <= TRACK;
                            end
                        end
                    end
                    TRACK: begin
                        if (hit && idx == cand_q) begin
                            hits_q <= hits_inc;
                            if (hits_inc == LOCK_C) begin
                                state_q    <= LOCKED;
                                note_valid <= 1'b1;
                                note_code  <= cand_q;
                                note_start <= 1'b1;
                            end
                        end else if (hit) begin
                            cand_q <= idx;
                            hits_q <= ONE_C;
                        end else begin
                            state_q <= ARMED;
                            hits_q  <= '0;
                        end
                    end
                    LOCKED: begin
                        if (hit && idx != cand_q) begin
                            note_end <= 1'b1;
                            cand_q   <= idx;
                            hits_q   <= ONE_C;
                            if (LOCK_COUNT == 1) begin
                                note_code  <= idx;
                                note_start <= 1'b1;
                            end else begin
                                state_q    <= TRACK;
                                note_valid <= 1'b0;
                                note_code  <= 2'd0;
                            end
                        end else if (!hit) begin
                            note_end   <= 1'b1;
                            state_q    <= ARMED;
                            hits_q     <= '0;
                            note_valid <= 1'b0;
                            note_code  <= 2'd0;
                        end
                    end
                endcase
            end else if (per_cnt_q == MAX_C && state_q != IDLE) begin
                // Silence: drop back to IDLE so the next edge only re-arms.
                state_q <= IDLE;
                hits_q  <= '0;
                if (state_q == LOCKED) begin
                    note_end   <= 1'b1;
                    note_valid <= 1'b0;
                    note_code  <= 2'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector: vector table of tone segments plus
// hand-written reset-hold and silence-timeout sequences.
module tb_tone_detector;

    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          audio_in;
    logic          note_valid;
    logic [1:0]    note_code;
    logic          note_start;
    logic          note_end;
    logic [PW-1:0] period_out;
    logic          period_stb;

    int checks = 0;
    int failures = 0;
    int n_start = 0;
    int n_end = 0;
    int n_stb = 0;
    int bad_code = 0;

    tone_detector #(
        .PER_W(PW), .NOTE0_PER(100), .NOTE1_PER(150), .NOTE2_PER(200),
        .NOTE3_PER(300), .TOL_SHIFT(3), .LOCK_COUNT(3), .MAX_PERIOD(1000)
    ) dut (
        .clk(clk), .rst(rst), .audio_in(audio_in),
        .note_valid(note_valid), .note_code(note_code),
        .note_start(note_start), .note_end(note_end),
        .period_out(period_out), .period_stb(period_stb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (note_start === 1'b1) n_start++;
        if (note_end === 1'b1) n_end++;
        if (period_stb === 1'b1) n_stb++;
        if (note_valid === 1'b0 && note_code !== 2'd0) bad_code++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int       per;
        int       n;
        bit       rst_before;
        logic     valid;
        logic [1:0] code;
        int       starts;
        int       ends;
        int       stbs;
        int       pout;
    } vec_t;

    vec_t tbl[8];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wave(input int per, input int n);
        for (int k = 0; k < n; k++) begin
            audio_in = 1'b1;
            step(per / 2);
            audio_in = 1'b0;
            step(per - per / 2);
        end
    endtask

    initial begin
        int s_start, s_end, s_stb;
        string tag;

        // per, n, rst_before, valid, code, starts, ends, stbs, period_out
        tbl[0] = '{150, 5, 0, 1'b1, 2'd1, 1, 0, 4, 150};
        tbl[1] = '{168, 3, 0, 1'b1, 2'd1, 0, 0, 3, 168};
        tbl[2] = '{170, 2, 0, 1'b0, 2'd0, 0, 1, 2, 170};
        tbl[3] = '{100, 5, 0, 1'b1, 2'd0, 1, 0, 5, 100};
        tbl[4] = '{200, 4, 0, 1'b1, 2'd2, 1, 1, 4, 200};
        tbl[5] = '{300, 5, 0, 1'b1, 2'd3, 1, 1, 5, 300};
        tbl[6] = '{300, 3, 1, 1'b0, 2'd0, 0, 0, 2, 300};
        tbl[7] = '{300, 1, 0, 1'b1, 2'd3, 1, 0, 1, 300};

        rst = 1'b1;
        audio_in = 1'b0;
        step(1);
        for (int i = 0; i < 5; i++) begin
            audio_in = ~audio_in;
            step(1);
            chk("rst_hold_outputs",
                {14'd0, note_valid, note_code, note_start, note_end,
                 period_stb, period_out}, 0);
        end
        audio_in = 1'b0;
        step(2);
        rst = 1'b0;
        step(3);
        chk("post_rst_pulses", n_start + n_end + n_stb, 0);

        for (int i = 0; i < 8; i++) begin
            s_start = n_start;
            s_end = n_end;
            s_stb = n_stb;
            if (tbl[i].rst_before) begin
                rst = 1'b1;
                step(1);
                $sformat(tag, "v%0d_rst_clear", i);
                chk(tag, {27'd0, note_valid, note_code, period_stb, note_end},
                    0);
                chk("v_rst_period_out", period_out, 0);
                rst = 1'b0;
            end
            wave(tbl[i].per, tbl[i].n);
            $sformat(tag, "v%0d_valid", i);
            chk(tag, note_valid, tbl[i].valid);
            $sformat(tag, "v%0d_code", i);
            chk(tag, note_code, tbl[i].code);
            $sformat(tag, "v%0d_starts", i);
            chk(tag, n_start - s_start, tbl[i].starts);
            $sformat(tag, "v%0d_ends", i);
            chk(tag, n_end - s_end, tbl[i].ends);
            $sformat(tag, "v%0d_stbs", i);
            chk(tag, n_stb - s_stb, tbl[i].stbs);
            $sformat(tag, "v%0d_period_out", i);
            chk(tag, period_out, tbl[i].pout);
        end

        // Hold high after lock: one more 300 rise, then silence timeout.
        s_start = n_start;
        s_end = n_end;
        s_stb = n_stb;
        audio_in = 1'b1;
        step(990);
        chk("to_still_valid", note_valid, 1'b1);
        chk("to_no_end_yet", n_end - s_end, 0);
        chk("to_last_stb", n_stb - s_stb, 1);
        step(20);
        chk("to_valid_dropped", note_valid, 1'b0);
        chk("to_code_zero", note_code, 2'd0);
        chk("to_end_pulse", n_end - s_end, 1);

        // Lone edge after silence must only arm, then time out quietly.
        audio_in = 1'b0;
        step(50);
        audio_in = 1'b1;
        step(1100);
        chk("lone_valid", note_valid, 1'b0);
        chk("lone_starts", n_start - s_start, 0);
        chk("lone_ends", n_end - s_end, 1);
        chk("lone_stbs", n_stb - s_stb, 1);
        chk("lone_period_out", period_out, 300);
        chk("code_zero_when_invalid", bad_code, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
